// File: rtl/tile_map_pkg.sv
// Shared types, field layout and slot extraction for the tile probe engine.
// Optional out-of-map handling in the engine is selected with TILE_PROBE_OOB_EN.
package tile_map_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BC_LSB  = 0;
    localparam int BC_W    = 3;
    localparam int BND_LSB = 3;
    localparam int BND_W   = 4;
    localparam int SLOT_W  = BND_LSB + BND_W;

    localparam logic [BC_W-1:0] GOAL_CODE = 3'b100;

    // Only the low SLOT_W bits of a tile slot carry information.
    function automatic logic [SLOT_W-1:0] slot_extract(input logic [31:0] word,
                                                       input int unsigned lane,
                                                       input int unsigned tile_bits = 8);
        return SLOT_W'(word >> (lane * tile_bits));
    endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Combinational pixel coordinate -> map RAM word address, lane and out-of-map flag.
// TILE_PROBE_OOB_EN: flag out-of-map probes instead of clamping them to the map edge.
module tile_addr_calc
    import tile_map_pkg::*;
#(
    parameter int COORD_W        = 10,
    parameter int TILE_SHIFT     = 5,
    parameter int MAP_COLS       = 20,
    parameter int MAP_ROWS       = 15,
    parameter int TILES_PER_WORD = 4,
    parameter int ADDR_W         = 7,
    parameter int LANE_W         = 2
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic [LANE_W-1:0]  lane,
    output logic               oob
);

    localparam int WPR = MAP_COLS / TILES_PER_WORD;

    logic [COORD_W-1:0] col_raw;
    logic [COORD_W-1:0] row_raw;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               col_over;
    logic               row_over;

    always_comb begin
        col_raw  = x >> TILE_SHIFT;
        row_raw  = y >> TILE_SHIFT;
        col_over = (col_raw >= COORD_W'(MAP_COLS));
        row_over = (row_raw >= COORD_W'(MAP_ROWS));
`ifdef TILE_PROBE_OOB_EN
        col = col_raw;
        row = row_raw;
        oob = col_over | row_over;
`else
        col = col_over ? COORD_W'(MAP_COLS - 1) : col_raw;
        row = row_over ? COORD_W'(MAP_ROWS - 1) : row_raw;
        oob = 1'b0;
`endif
        addr = ADDR_W'(32'(row) * WPR + 32'(col) / TILES_PER_WORD);
        lane = LANE_W'(32'(col) % TILES_PER_WORD);
    end

endmodule

// File: rtl/tile_probe_engine.sv
// Sequential multi-probe tile lookup against the packed map RAM, one read per probe.
// TILE_PROBE_OOB_EN: out-of-map probes skip the read and report a solid, flagged tile.
module tile_probe_engine
    import tile_map_pkg::*;
#(
    parameter int COORD_W        = 10,
    parameter int TILE_SHIFT     = 5,
    parameter int MAP_COLS       = 20,
    parameter int MAP_ROWS       = 15,
    parameter int TILES_PER_WORD = 4,
    parameter int TILE_BITS      = 8,
    parameter int NUM_PROBES     = 4,
    parameter int ADDR_W         = 7,
    parameter int RD_LAT         = 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          start,
    input  logic [NUM_PROBES*COORD_W-1:0] probe_x,
    input  logic [NUM_PROBES*COORD_W-1:0] probe_y,
    input  logic                          all_collected,
    output logic                          mem_rd,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [31:0]                   mem_q,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_PROBES*BC_W-1:0]    blockcode_out,
    output logic [NUM_PROBES*BND_W-1:0]   bounds_out,
    output logic [NUM_PROBES-1:0]         oob,
    output logic                          goal_hit
);

    localparam int LANE_W = (TILES_PER_WORD > 1) ? $clog2(TILES_PER_WORD) : 1;
    localparam int P_W    = $clog2(NUM_PROBES);

    state_t                       state_q, state_d;
    logic [P_W-1:0]               p_q, p_d;
    logic [1:0]                   wcnt_q, wcnt_d;
    logic [NUM_PROBES*BC_W-1:0]   bc_q, bc_d;
    logic [NUM_PROBES*BND_W-1:0]  bnd_q, bnd_d;
    logic [NUM_PROBES-1:0]        oob_q, oob_d;
    logic                         goal_q, goal_d;

    logic [COORD_W-1:0]           px_q [NUM_PROBES];
    logic [COORD_W-1:0]           py_q [NUM_PROBES];

    logic [COORD_W-1:0]           cur_x;
    logic [COORD_W-1:0]           cur_y;
    logic [ADDR_W-1:0]            calc_addr;
    logic [LANE_W-1:0]            calc_lane;
    logic                         calc_oob;
    logic [SLOT_W-1:0]            slot;
    logic                         any_goal;

    // Coordinates are plain data: captured on an accepted start, never reset.
    always_ff @(posedge CLK) begin
        if (state_q == IDLE && start) begin
            for (int i = 0; i < NUM_PROBES; i++) begin
                px_q[i] <= probe_x[i*COORD_W +: COORD_W];
                py_q[i] <= probe_y[i*COORD_W +: COORD_W];
            end
        end
    end

    assign cur_x = px_q[p_q];
    assign cur_y = py_q[p_q];

    tile_addr_calc #(
        .COORD_W        (COORD_W),
        .TILE_SHIFT     (TILE_SHIFT),
        .MAP_COLS       (MAP_COLS),
        .MAP_ROWS       (MAP_ROWS),
        .TILES_PER_WORD (TILES_PER_WORD),
        .ADDR_W         (ADDR_W),
        .LANE_W         (LANE_W)
    ) u_addr (
        .x    (cur_x),
        .y    (cur_y),
        .addr (calc_addr),
        .lane (calc_lane),
        .oob  (calc_oob)
    );

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        wcnt_d   = wcnt_q;
        bc_d     = bc_q;
        bnd_d    = bnd_q;
        oob_d    = oob_q;
        goal_d   = goal_q;
        slot     = slot_extract(mem_q, 32'(calc_lane), TILE_BITS);
        any_goal = 1'b0;
        for (int i = 0; i < NUM_PROBES; i++) begin
            if (bc_q[i*BC_W +: BC_W] == GOAL_CODE) begin
                any_goal = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    p_d     = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                if (wcnt_q == 2'(RD_LAT - 1)) begin
                    // Out-of-map probes never read; they report a solid tile.
                    if (calc_oob) begin
                        bc_d[int'(p_q)*BC_W +: BC_W]    = '0;
                        bnd_d[int'(p_q)*BND_W +: BND_W] = '1;
                    end else begin
                        bc_d[int'(p_q)*BC_W +: BC_W]    = slot[BC_LSB +: BC_W];
                        bnd_d[int'(p_q)*BND_W +: BND_W] = slot[BND_LSB +: BND_W];
                    end
                    oob_d[p_q] = calc_oob;
                    if (p_q == P_W'(NUM_PROBES - 1)) begin
                        state_d = DONE;
                    end else begin
                        p_d     = p_q + 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                goal_d  = any_goal && all_collected;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            p_q     <= '0;
            wcnt_q  <= '0;
            bc_q    <= '0;
            bnd_q   <= '0;
            oob_q   <= '0;
            goal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            wcnt_q  <= wcnt_d;
            bc_q    <= bc_d;
            bnd_q   <= bnd_d;
            oob_q   <= oob_d;
            goal_q  <= goal_d;
        end
    end

    assign mem_rd        = (state_q == ISSUE) && !calc_oob;
    assign mem_addr      = mem_rd ? calc_addr : '0;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign blockcode_out = bc_q;
    assign bounds_out    = bnd_q;
    assign oob           = oob_q;
    assign goal_hit      = goal_q;

endmodule

// File: tb/tb_tile_probe_engine.sv
// Directed bench for tile_probe_engine with a 1-cycle-latency map RAM model.
module tb_tile_probe_engine;

    localparam int NP = 4;
    localparam int CW = 10;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           start;
    logic [NP*CW-1:0] probe_x;
    logic [NP*CW-1:0] probe_y;
    logic           all_collected;
    logic           mem_rd;
    logic [6:0]     mem_addr;
    logic [31:0]    mem_q;
    logic           busy;
    logic           done;
    logic [NP*3-1:0] blockcode_out;
    logic [NP*4-1:0] bounds_out;
    logic [NP-1:0]  oob;
    logic           goal_hit;

    logic [31:0]    mem [128];
    int             rd_count = 0;
    int             rd_log [64];
    int             done_cnt = 0;
    int             n_chk = 0;
    int             n_fail = 0;

    tile_probe_engine dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .start         (start),
        .probe_x       (probe_x),
        .probe_y       (probe_y),
        .all_collected (all_collected),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_q         (mem_q),
        .busy          (busy),
        .done          (done),
        .blockcode_out (blockcode_out),
        .bounds_out    (bounds_out),
        .oob           (oob),
        .goal_hit      (goal_hit)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_rd) begin
            if (rd_count < 64) rd_log[rd_count] = int'(mem_addr);
            rd_count = rd_count + 1;
            mem_q <= mem[mem_addr];
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP*CW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    // Returns cycles from the start cycle to the done cycle (40 on timeout).
    task automatic run_req(input logic [NP*CW-1:0] xs, input logic [NP*CW-1:0] ys,
                           input bit repulse, output int n, output int rd_base);
        @(negedge CLK);
        probe_x = xs;
        probe_y = ys;
        start   = 1'b1;
        rd_base = rd_count;
        n       = 0;
        while (n < 40) begin
            @(negedge CLK);
            n++;
            start = repulse && (n == 3 || n == 5);
            if (start) begin
                probe_x = '0;
                probe_y = '0;
            end
            if (done) break;
        end
        start = 1'b0;
    endtask

    int n;
    int rb;
    int db;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0000_0019;
        mem[5]  = 32'h002C_0000;
        mem[19] = 32'h5A00_0000;
        mem[30] = 32'h3300_0000;
        mem_q         = 32'h0;
        RESET         = 1'b0;
        start         = 1'b0;
        probe_x       = '0;
        probe_y       = '0;
        all_collected = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_bc", blockcode_out, 0);
        check("rst_bnd", bounds_out, 0);
        check("rst_oob", oob, 0);
        check("rst_goal", goal_hit, 0);
        RESET = 1'b1;
        @(negedge CLK);

        // Goal tile on probe 0, others on tile (0,0)
        all_collected = 1'b1;
        run_req(pack4(70, 0, 0, 0), pack4(40, 0, 0, 0), 1'b0, n, rb);
        check("t1_latency", n, 9);
        check("t1_rd_count", rd_count - rb, 4);
        check("t1_addr0", rd_log[rb], 5);
        check("t1_bc0", blockcode_out[2:0], 3'b100);
        check("t1_bnd0", bounds_out[3:0], 4'b0101);
        check("t1_bc_all", blockcode_out, 12'h24C);
        check("t1_bnd_all", bounds_out, 16'h3335);
        @(negedge CLK);
        check("t1_goal", goal_hit, 1);
        check("t1_done_pulse", done, 0);
        check("t1_busy_idle", busy, 0);

        // Reset in the WAIT slot of probe 2 aborts the request
        db = done_cnt;
        @(negedge CLK);
        probe_x = pack4(0, 0, 0, 0);
        probe_y = pack4(0, 0, 0, 0);
        start   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        check("t4_busy_before", busy, 1);
        RESET = 1'b0;
        #1;
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_mem_rd", mem_rd, 0);
        check("t4_bc", blockcode_out, 0);
        check("t4_bnd", bounds_out, 0);
        check("t4_oob", oob, 0);
        check("t4_goal", goal_hit, 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (10) @(negedge CLK);
        check("t4_no_done", done_cnt - db, 0);

        // Fresh request after the abort: all probes on tile (0,0)
        run_req(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 1'b0, n, rb);
        check("t2_latency", n, 9);
        check("t2_rd_count", rd_count - rb, 4);
        for (int k = 0; k < 4; k++) check("t2_addr", rd_log[rb + k], 0);
        check("t2_bc_all", blockcode_out, 12'h249);
        check("t2_bnd_all", bounds_out, 16'h3333);
        @(negedge CLK);
        check("t2_goal", goal_hit, 0);

        // Probe 1 beyond the right edge of the map
        run_req(pack4(70, 700, 0, 100), pack4(40, 100, 0, 200), 1'b0, n, rb);
        check("t3_latency", n, 9);
`ifdef TILE_PROBE_OOB_EN
        check("t3_rd_count", rd_count - rb, 3);
        check("t3_addr0", rd_log[rb], 5);
        check("t3_addr2", rd_log[rb + 1], 0);
        check("t3_addr3", rd_log[rb + 2], 30);
        check("t3_bc_all", blockcode_out, 12'h644);
        check("t3_bnd_all", bounds_out, 16'h63F5);
        check("t3_oob", oob, 4'b0010);
`else
        check("t3_rd_count", rd_count - rb, 4);
        check("t3_addr1", rd_log[rb + 1], 19);
        check("t3_addr3", rd_log[rb + 3], 30);
        check("t3_bc_all", blockcode_out, 12'h654);
        check("t3_bnd_all", bounds_out, 16'h63B5);
        check("t3_oob", oob, 4'b0000);
`endif
        @(negedge CLK);
        check("t3_goal", goal_hit, 1);

        // start re-pulsed while busy; goal tile with coins outstanding
        all_collected = 1'b0;
        db = done_cnt;
        run_req(pack4(70, 0, 0, 0), pack4(40, 0, 0, 0), 1'b1, n, rb);
        check("t5_latency", n, 9);
        check("t5_rd_count", rd_count - rb, 4);
        check("t5_bc_all", blockcode_out, 12'h24C);
        check("t5_bnd_all", bounds_out, 16'h3335);
        @(negedge CLK);
        check("t5_goal", goal_hit, 0);
        repeat (20) @(negedge CLK);
        check("t5_one_done", done_cnt - db, 1);
        check("t5_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
